// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_pkg;

    localparam int unsigned ROW_W = 2;
    localparam int unsigned COL_W = 2;
    localparam int unsigned ROWS  = 4;

    localparam logic [ROWS-1:0] IDLE_ROWS = 4'hF;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        PRESSED,
        REL_DB
    } state_e;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } key_code_t;

    // Index of the lowest active-low row; F0 has the highest priority.
    function automatic logic [ROW_W-1:0] lowest_row(input logic [ROWS-1:0] rows);
        logic [ROW_W-1:0] idx;
        idx = '0;
        for (int i = int'(ROWS) - 1; i >= 0; i--) begin
            if (!rows[i]) idx = ROW_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_sync_2ff.sv
// Two-flop synchronizer with a configurable reset value.
module sync_2ff #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with press/release debounce and encoded key events.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100_000,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned REPEAT_DLY   = 50_000_000,
    parameter int unsigned REPEAT_PER   = 10_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ROWS-1:0]        rows_n,
    output logic [COL_W-1:0]       col_sel,
    output logic [ROW_W+COL_W-1:0] key_code,
    output logic                   key_valid,
    output logic                   key_held
);

    localparam int unsigned MAX_AB = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
    localparam int unsigned MAX_CD = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

    logic [ROWS-1:0]  rs;
    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    key_code_t        code_q, code_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic [CNT_W-1:0] slot_q, slot_d;
    logic [CNT_W-1:0] db_q, db_d;
    logic [ROWS-1:0]  pat_q, pat_d;
`ifdef KEYPAD_REPEAT_EN
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             rep_q, rep_d;
`endif

    sync_2ff #(
        .WIDTH   (ROWS),
        .RST_VAL (IDLE_ROWS)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rows_n),
        .q     (rs)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        slot_d  = slot_q;
        db_d    = db_q;
        pat_d   = pat_q;
`ifdef KEYPAD_REPEAT_EN
        hold_d  = hold_q;
        rep_d   = rep_q;
`endif
        unique case (state_q)
            SCAN: begin
                if (slot_q == CNT_W'(SCAN_DIV - 1)) begin
                    slot_d = '0;
                    if (rs != IDLE_ROWS) begin
                        pat_d   = rs;
                        db_d    = '0;
                        state_d = PRESS_DB;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end else begin
                    slot_d = slot_q + CNT_W'(1);
                end
            end
            PRESS_DB: begin
                if (rs != pat_q) begin
                    state_d = SCAN;
                    slot_d  = '0;
                    col_d   = col_q + COL_W'(1);
                end else if (db_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    state_d    = PRESSED;
                    valid_d    = 1'b1;
                    held_d     = 1'b1;
                    code_d.row = lowest_row(rs);
                    code_d.col = col_q;
`ifdef KEYPAD_REPEAT_EN
                    hold_d     = '0;
                    rep_d      = 1'b0;
`endif
                end else begin
                    db_d = db_q + CNT_W'(1);
                end
            end
            PRESSED: begin
`ifdef KEYPAD_REPEAT_EN
                // First repeat after REPEAT_DLY cycles, then one every REPEAT_PER.
                if (hold_q == (rep_q ? CNT_W'(REPEAT_PER - 1) : CNT_W'(REPEAT_DLY - 1))) begin
                    valid_d = 1'b1;
                    hold_d  = '0;
                    rep_d   = 1'b1;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
`endif
                if (rs == IDLE_ROWS) begin
                    db_d    = '0;
                    state_d = REL_DB;
                end
            end
            REL_DB: begin
                if (rs != IDLE_ROWS) begin
                    state_d = PRESSED;
                end else if (db_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    held_d  = 1'b0;
                    col_d   = col_q + COL_W'(1);
                    slot_d  = '0;
                    state_d = SCAN;
                end else begin
                    db_d = db_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SCAN;
            col_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            slot_q  <= '0;
            db_q    <= '0;
            pat_q   <= IDLE_ROWS;
`ifdef KEYPAD_REPEAT_EN
            hold_q  <= '0;
            rep_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            slot_q  <= slot_d;
            db_q    <= db_d;
            pat_q   <= pat_d;
`ifdef KEYPAD_REPEAT_EN
            hold_q  <= hold_d;
            rep_q   <= rep_d;
`endif
        end
    end

    assign col_sel   = col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: directed vector table, repeat check, random keypad traffic.
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CYC = 8;
    localparam int REPEAT_DLY   = 20;
    localparam int REPEAT_PER   = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rows_n;
    logic [1:0] col_sel;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = '0;   // bit r*4+c set = key at row r, column c pressed
    logic        glitch = 1'b0;

    int checks = 0;
    int failures = 0;

    keypad_scan_ctrl #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_DLY   (REPEAT_DLY),
        .REPEAT_PER   (REPEAT_PER)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rows_n    (rows_n),
        .col_sel   (col_sel),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row reads low when a pressed key sits in the driven column.
    always_comb begin
        rows_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!glitch && keys[r*4 + int'(col_sel)]) rows_n[r] = 1'b0;
        end
    end

    logic [3:0] s_rows;
    logic       s_rst;
    always @(posedge clk) begin
        s_rows <= rows_n;
        s_rst  <= rst_n;
    end

    // Reference model: phases timed by edge stamps, rows delayed through a 2-entry queue.
    localparam int PH_SCAN = 0, PH_CONF = 1, PH_HOLD = 2, PH_REL = 3;
    int         phase = PH_SCAN;
    int         mark = 0;
    int         cyc = 0;
    int         hold_t = 0;
    logic [3:0] pat = 4'hF;
    logic [3:0] rq[$];
    logic [1:0] m_col = '0;
    logic [3:0] m_code = '0;
    logic       m_valid = 1'b0;
    logic       m_held = 1'b0;

    function automatic logic [1:0] lowest(input logic [3:0] r);
        for (int i = 0; i < 4; i++) if (!r[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic logic [15:0] key(input int r, input int c);
        return 16'(1) << (r*4 + c);
    endfunction

    task automatic model_edge();
        logic [3:0] rs;
        int n;
        cyc++;
        if (!s_rst) begin
            phase = PH_SCAN; mark = cyc;
            m_col = '0; m_code = '0; m_valid = 1'b0; m_held = 1'b0;
            rq.delete(); rq.push_back(4'hF); rq.push_back(4'hF);
        end else begin
            rs = rq.pop_front();
            rq.push_back(s_rows);
            n = cyc - mark;
            m_valid = 1'b0;
            case (phase)
                PH_SCAN: if (n == SCAN_DIV) begin
                    mark = cyc;
                    if (rs != 4'hF) begin pat = rs; phase = PH_CONF; end
                    else m_col = m_col + 2'd1;
                end
                PH_CONF: if (rs != pat) begin
                    phase = PH_SCAN; mark = cyc; m_col = m_col + 2'd1;
                end else if (n == DEBOUNCE_CYC) begin
                    m_code = {lowest(rs), m_col};
                    m_valid = 1'b1; m_held = 1'b1;
                    phase = PH_HOLD; hold_t = 0;
                end
                PH_HOLD: begin
                    hold_t++;
`ifdef KEYPAD_REPEAT_EN
                    if (hold_t >= REPEAT_DLY && (hold_t - REPEAT_DLY) % REPEAT_PER == 0) m_valid = 1'b1;
`endif
                    if (rs == 4'hF) begin phase = PH_REL; mark = cyc; end
                end
                default: if (rs != 4'hF) begin
                    phase = PH_HOLD;
                end else if (n == DEBOUNCE_CYC) begin
                    m_held = 1'b0; m_col = m_col + 2'd1; phase = PH_SCAN; mark = cyc;
                end
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [1:0] ec, input logic [3:0] ek,
                       input logic ev, input logic eh);
        checks++;
        if (col_sel !== ec || key_code !== ek || key_valid !== ev || key_held !== eh) begin
            failures++;
            $display("FAIL %s @%0t: got col=%0d code=%b valid=%b held=%b, want col=%0d code=%b valid=%b held=%b",
                     name, $time, col_sel, key_code, key_valid, key_held, ec, ek, ev, eh);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        chk("model", m_col, m_code, m_valid, m_held);
    endtask

    typedef struct {
        string       name;
        logic        rst;
        logic [15:0] keys;
        logic        glitch;
        int          n;
        logic [1:0]  col;
        logic [3:0]  code;
        logic        v;
        logic        h;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input string nm, input logic rs, input logic [15:0] k, input logic g,
                                input int n, input logic [1:0] c, input logic [3:0] cd,
                                input logic v, input logic h);
        vec_t t;
        t.name = nm; t.rst = rs; t.keys = k; t.glitch = g; t.n = n;
        t.col = c; t.code = cd; t.v = v; t.h = h;
        return t;
    endfunction

    logic [15:0] k21, k03_23, k10;
    logic [63:0] got_mask, exp_mask;
    int          sel, len, rc, waited;

    initial begin
        k21    = key(2, 1);
        k03_23 = key(0, 3) | key(2, 3);
        k10    = key(1, 0);

        vt.push_back(mk("reset",          0, '0,     0,  2, 2'd0, 4'b0000, 0, 0));
        vt.push_back(mk("scan_c1",        1, '0,     0,  4, 2'd1, 4'b0000, 0, 0));
        vt.push_back(mk("scan_c2",        1, '0,     0,  4, 2'd2, 4'b0000, 0, 0));
        vt.push_back(mk("scan_c3",        1, '0,     0,  4, 2'd3, 4'b0000, 0, 0));
        vt.push_back(mk("scan_wrap",      1, '0,     0,  4, 2'd0, 4'b0000, 0, 0));
        vt.push_back(mk("press_db",       1, k21,    0, 15, 2'd1, 4'b0000, 0, 0));
        vt.push_back(mk("accept",         1, k21,    0,  1, 2'd1, 4'b1001, 1, 1));
        vt.push_back(mk("one_pulse",      1, k21,    0,  1, 2'd1, 4'b1001, 0, 1));
        vt.push_back(mk("held_frozen",    1, k21,    0, 20, 2'd1, 4'b1001, 0, 1));
        vt.push_back(mk("release_db",     1, '0,     0, 10, 2'd1, 4'b1001, 0, 1));
        vt.push_back(mk("released",       1, '0,     0,  1, 2'd2, 4'b1001, 0, 0));
        vt.push_back(mk("press_again",    1, k21,    0, 18, 2'd1, 4'b1001, 0, 0));
        vt.push_back(mk("glitch",         1, k21,    1,  1, 2'd1, 4'b1001, 0, 0));
        vt.push_back(mk("abort",          1, '0,     0,  2, 2'd2, 4'b1001, 0, 0));
        vt.push_back(mk("resume_c2",      1, '0,     0,  3, 2'd2, 4'b1001, 0, 0));
        vt.push_back(mk("resume_c3",      1, '0,     0,  1, 2'd3, 4'b1001, 0, 0));
        vt.push_back(mk("multi_db",       1, k03_23, 0, 11, 2'd3, 4'b1001, 0, 0));
        vt.push_back(mk("row0_wins",      1, k03_23, 0,  1, 2'd3, 4'b0011, 1, 1));
        vt.push_back(mk("bounce_hi",      1, '0,     0,  3, 2'd3, 4'b0011, 0, 1));
        vt.push_back(mk("bounce_lo",      1, k03_23, 0,  1, 2'd3, 4'b0011, 0, 1));
        vt.push_back(mk("bounce_held",    1, '0,     0, 10, 2'd3, 4'b0011, 0, 1));
        vt.push_back(mk("clean_release",  1, '0,     0,  1, 2'd0, 4'b0011, 0, 0));
        vt.push_back(mk("accept_c0",      1, k10,    0, 12, 2'd0, 4'b0100, 1, 1));
        vt.push_back(mk("hold_c0",        1, k10,    0,  3, 2'd0, 4'b0100, 0, 1));
        vt.push_back(mk("reset_mid_hold", 0, '0,     0,  1, 2'd0, 4'b0000, 0, 0));
        vt.push_back(mk("scan_post_rst",  1, '0,     0,  4, 2'd1, 4'b0000, 0, 0));

        foreach (vt[i]) begin
            rst_n  = vt[i].rst;
            keys   = vt[i].keys;
            glitch = vt[i].glitch;
            for (int c = 0; c < vt[i].n; c++) tick();
            chk(vt[i].name, vt[i].col, vt[i].code, vt[i].v, vt[i].h);
        end

        // Long hold: pulse offsets relative to the accept pulse.
        keys = key(3, 1);
        waited = 0;
        while (!key_valid && waited < 200) begin tick(); waited++; end
        checks++;
        if (!key_valid) begin
            failures++;
            $display("FAIL repeat_accept: key_valid never rose within %0d cycles, want a pulse", waited);
        end
        got_mask = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (key_valid) got_mask = got_mask | (64'(1) << k);
        end
        exp_mask = '0;
`ifdef KEYPAD_REPEAT_EN
        exp_mask = (64'(1) << 20) | (64'(1) << 26) | (64'(1) << 32) | (64'(1) << 38);
`endif
        checks++;
        if (got_mask !== exp_mask) begin
            failures++;
            $display("FAIL repeat_pulses: offsets mask got %h, want %h", got_mask, exp_mask);
        end
        keys = '0;
        waited = 0;
        while (key_held && waited < 100) begin tick(); waited++; end
        checks++;
        if (key_held) begin
            failures++;
            $display("FAIL repeat_release: key_held still %b after %0d cycles, want 0", key_held, waited);
        end

        // Random keypad traffic against the model.
        rc = 0;
        while (rc < 2500) begin
            sel = $urandom_range(0, 99);
            len = $urandom_range(1, 40);
            if (sel < 3) begin
                rst_n = 1'b0; keys = '0; glitch = 1'b0;
                tick();
                rst_n = 1'b1;
                rc++;
            end else begin
                if (sel < 40)      keys = '0;
                else if (sel < 85) keys = 16'(1) << $urandom_range(0, 15);
                else               keys = 16'($urandom);
                for (int k = 0; k < len; k++) begin
                    glitch = ($urandom_range(0, 19) == 0);
                    tick();
                    rc++;
                end
                glitch = 1'b0;
            end
        end
        keys = '0;
        for (int k = 0; k < 30; k++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
